// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked sequential ALU. Accepts one operation over a
//                valid/ready input channel and returns a registered result
//                and zero flag over a valid/ready output channel.
//                Single-cycle ops finish in one cycle. When the macro
//                ALU_MUL_EN is defined, an iterative shift-add multiplier
//                (WIDTH+1 cycles from the handshake) is compiled in.
//                Without it, ALU_MUL behaves like an unknown code.
//  Revision    : 1.0 - initial release
// ============================================================================

// Opcode encodings shared with decode (constants.svh contents).
`ifndef ALU_ADD
`define ALU_ADD  5'h00
`define ALU_SUB  5'h01
`define ALU_AND  5'h02
`define ALU_OR   5'h03
`define ALU_XOR  5'h04
`define ALU_SLL  5'h05
`define ALU_SRL  5'h06
`define ALU_SRA  5'h07
`define ALU_SLT  5'h08
`define ALU_SLTU 5'h09
`define ALU_MUL  5'h0A
`endif

module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_function,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_eq_zero
);

    localparam int c_SHW = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
`ifdef ALU_MUL_EN
    localparam logic [1:0] c_BUSY = 2'd1;
`endif
    localparam logic [1:0] c_DONE = 2'd2;

    // Registered state
    logic [1:0]       r_state_q;
    logic [WIDTH-1:0] r_result_q;
    logic             r_zero_q;

    // Next-state values
    logic [1:0]       w_state_d;
    logic [WIDTH-1:0] w_result_d;
    logic             w_zero_d;

    // Datapath helpers
    logic [c_SHW-1:0] w_shamt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_mul;

`ifdef ALU_MUL_EN
    localparam logic [c_SHW-1:0] c_LAST_STEP = c_SHW'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc_q,    w_acc_d;
    logic [WIDTH-1:0] r_mcand_q,  w_mcand_d;
    logic [WIDTH-1:0] r_mplier_q, w_mplier_d;
    logic [c_SHW-1:0] r_count_q,  w_count_d;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc_sum;

    assign w_addend  = r_mplier_q[0] ? r_mcand_q : '0;
    assign w_acc_sum = r_acc_q + w_addend;
    assign w_is_mul  = (alu_function == `ALU_MUL);
`else
    assign w_is_mul  = 1'b0;
`endif

    // Only the low log2(WIDTH) bits of op_b select the shift distance.
    assign w_shamt    = op_b[c_SHW-1:0];
    assign w_in_ready = (r_state_q == c_IDLE) || ((r_state_q == c_DONE) && out_ready);
    assign w_accept   = in_valid && w_in_ready;

    assign in_ready       = w_in_ready;
    assign out_valid      = (r_state_q == c_DONE);
    assign result         = r_result_q;
    assign result_eq_zero = r_zero_q;

    // Single-cycle operation result; MUL and unknown codes yield zero here.
    always_comb begin
        w_alu_res = '0;
        case (alu_function)
            `ALU_ADD:  w_alu_res = op_a + op_b;
            `ALU_SUB:  w_alu_res = op_a - op_b;
            `ALU_AND:  w_alu_res = op_a & op_b;
            `ALU_OR:   w_alu_res = op_a | op_b;
            `ALU_XOR:  w_alu_res = op_a ^ op_b;
            `ALU_SLL:  w_alu_res = op_a << w_shamt;
            `ALU_SRL:  w_alu_res = op_a >> w_shamt;
            `ALU_SRA:  w_alu_res = $signed(op_a) >>> w_shamt;
            `ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            `ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            default:   w_alu_res = '0;
        endcase
    end

    // Control FSM and result/multiplier next-state logic.
    always_comb begin
        w_state_d  = r_state_q;
        w_result_d = r_result_q;
        w_zero_d   = r_zero_q;
`ifdef ALU_MUL_EN
        w_acc_d    = r_acc_q;
        w_mcand_d  = r_mcand_q;
        w_mplier_d = r_mplier_q;
        w_count_d  = r_count_q;
`endif
        case (r_state_q)
            c_IDLE, c_DONE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
`ifdef ALU_MUL_EN
                        w_acc_d    = '0;
                        w_mcand_d  = op_a;
                        w_mplier_d = op_b;
                        w_count_d  = '0;
                        w_state_d  = c_BUSY;
`endif
                    end else begin
                        w_result_d = w_alu_res;
                        w_zero_d   = (w_alu_res == '0);
                        w_state_d  = c_DONE;
                    end
                end else if (r_state_q == c_DONE && out_ready) begin
                    w_state_d = c_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            c_BUSY: begin
                // One shift-add step per cycle; the final step's sum is the product.
                w_acc_d    = w_acc_sum;
                w_mcand_d  = r_mcand_q << 1;
                w_mplier_d = r_mplier_q >> 1;
                w_count_d  = r_count_q + 1'b1;
                if (r_count_q == c_LAST_STEP) begin
                    w_result_d = w_acc_sum;
                    w_zero_d   = (w_acc_sum == '0);
                    w_state_d  = c_DONE;
                end
            end
`endif
            default: w_state_d = c_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset discards any pending op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= c_IDLE;
            r_result_q <= '0;
            r_zero_q   <= 1'b1;
`ifdef ALU_MUL_EN
            r_acc_q    <= '0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_count_q  <= '0;
`endif
        end else begin
            r_state_q  <= w_state_d;
            r_result_q <= w_result_d;
            r_zero_q   <= w_zero_d;
`ifdef ALU_MUL_EN
            r_acc_q    <= w_acc_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_count_q  <= w_count_d;
`endif
        end
    end

endmodule

`default_nettype wire
